// File: rtl/loop_ctrl.sv
// loop_ctrl: bracket-loop sequencer for a byte-coded interpreter core.
// Resolves "[" / "]" instructions: keeps a return-address stack for
// open loops and, when a loop is skipped ("[" on a zero cell), scans
// program memory forward to find the matching "]".
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   cmd_valid      bracket instruction presented (accepted only in IDLE)
//   cmd_op[7:0]    opcode, 0x5B "[" or 0x5D "]"; anything else ignored
//   cmd_pc[7:0]    program address of the instruction
//   cell_zero      current data cell is zero
//   cmd_ready      high while idle
//   done           one-cycle pulse, next_pc valid
//   next_pc[7:0]   program address to continue from
//   scan_ren       program memory read enable (forward scan)
//   scan_addr[7:0] program memory read address
//   scan_rval[7:0] program byte, returned the cycle after scan_ren
//   err_clr        synchronous clear of the sticky error flags
//   err_overflow   sticky: push on a full stack
//   err_unmatched  sticky: unmatched bracket seen
//   depth[7:0]     stack occupancy, 0..STACK_DEPTH
module loop_ctrl #(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_op,
  input  logic [7:0] cmd_pc,
  input  logic       cell_zero,
  output logic       cmd_ready,
  output logic       done,
  output logic [7:0] next_pc,
  output logic       scan_ren,
  output logic [7:0] scan_addr,
  input  logic [7:0] scan_rval,
  input  logic       err_clr,
  output logic       err_overflow,
  output logic       err_unmatched,
  output logic [7:0] depth
);

  localparam int unsigned AW        = $clog2(STACK_DEPTH);
  localparam logic [7:0]  FULL      = 8'(STACK_DEPTH);
  localparam logic [7:0]  OP_OPEN   = 8'h5B;
  localparam logic [7:0]  OP_CLOSE  = 8'h5D;

  typedef enum logic [1:0] {IDLE, RESP, SCAN_RD, SCAN_CHK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  stack_q [STACK_DEPTH];
  logic [7:0]  depth_q, depth_d;
  logic [8:0]  nest_q, nest_d;
  logic [7:0]  next_pc_q, next_pc_d;
  logic [7:0]  scan_addr_q, scan_addr_d;
  logic [7:0]  start_pc_q, start_pc_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_unm_q, err_unm_d;

  logic          push_en, pop_en;
  logic          set_ovf, set_unm;
  logic [AW-1:0] push_idx, top_idx;
  logic [7:0]    top_val;
  logic [7:0]    pc_inc, addr_inc;
  logic [8:0]    nest_nxt;

  assign push_idx = AW'(depth_q);
  assign top_idx  = AW'(depth_q - 8'd1);
  assign top_val  = stack_q[top_idx];
  assign pc_inc   = cmd_pc + 8'd1;
  assign addr_inc = scan_addr_q + 8'd1;

  always_comb begin
    nest_nxt = nest_q;
    case (scan_rval)
      OP_OPEN:  nest_nxt = nest_q + 9'd1;
      OP_CLOSE: nest_nxt = nest_q - 9'd1;
      default:  nest_nxt = nest_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    nest_d      = nest_q;
    next_pc_d   = next_pc_q;
    scan_addr_d = scan_addr_q;
    start_pc_d  = start_pc_q;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    set_ovf     = 1'b0;
    set_unm     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_OPEN) begin
            if (cell_zero) begin
              nest_d      = 9'd1;
              scan_addr_d = pc_inc;
              start_pc_d  = cmd_pc;
              state_d     = SCAN_RD;
            end else begin
              if (depth_q == FULL) set_ovf = 1'b1;
              else                 push_en = 1'b1;
              next_pc_d = pc_inc;
              state_d   = RESP;
            end
          end else if (cmd_op == OP_CLOSE) begin
            if (depth_q == 8'd0) begin
              set_unm   = 1'b1;
              next_pc_d = pc_inc;
            end else if (cell_zero) begin
              pop_en    = 1'b1;
              next_pc_d = pc_inc;
            end else begin
              // Jump past the "[" so it is not evaluated again.
              next_pc_d = top_val + 8'd1;
            end
            state_d = RESP;
          end
        end
      end
      SCAN_RD: state_d = SCAN_CHK;
      SCAN_CHK: begin
        nest_d = nest_nxt;
        if (scan_rval == 8'h00) begin
          set_unm   = 1'b1;
          next_pc_d = scan_addr_q;
          state_d   = RESP;
        end else if (nest_nxt == 9'd0) begin
          next_pc_d = addr_inc;
          state_d   = RESP;
        end else if (addr_inc == start_pc_q) begin
          // Whole address space scanned without finding a match.
          set_unm     = 1'b1;
          scan_addr_d = addr_inc;
          next_pc_d   = addr_inc;
          state_d     = RESP;
        end else begin
          scan_addr_d = addr_inc;
          state_d     = SCAN_RD;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    if (push_en)     depth_d = depth_q + 8'd1;
    else if (pop_en) depth_d = depth_q - 8'd1;
  end

  // A flag being set in the same cycle as err_clr stays set.
  assign err_ovf_d = set_ovf ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
  assign err_unm_d = set_unm ? 1'b1 : (err_clr ? 1'b0 : err_unm_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      nest_q      <= '0;
      next_pc_q   <= '0;
      scan_addr_q <= '0;
      start_pc_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unm_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      nest_q      <= nest_d;
      next_pc_q   <= next_pc_d;
      scan_addr_q <= scan_addr_d;
      start_pc_q  <= start_pc_d;
      err_ovf_q   <= err_ovf_d;
      err_unm_q   <= err_unm_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      stack_q[push_idx] <= cmd_pc;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign done          = (state_q == RESP);
  assign scan_ren      = (state_q == SCAN_RD);
  assign next_pc       = next_pc_q;
  assign scan_addr     = scan_addr_q;
  assign err_overflow  = err_ovf_q;
  assign err_unmatched = err_unm_q;
  assign depth         = depth_q;

endmodule
